// File: rtl/calc_core.sv
// calc_core: REG_NUM x DATA_W register file with a handshaked single-cycle ALU
// and a multi-cycle shift-add multiplier. Produces a registered result,
// Z/N/C flags and a one-cycle OutValid strobe per completed instruction.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | ready for an instruction; non-MUL ops complete on the accept edge
// S_MUL  | shift-add multiply in progress, one multiplier bit per cycle
module calc_core #(
  parameter int DATA_W  = 10,
  parameter int REG_NUM = 4,
  localparam int AW     = $clog2(REG_NUM)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [3:0]        Op,
  input  logic [AW-1:0]     WA,
  input  logic [AW-1:0]     RAA,
  input  logic [AW-1:0]     RBA,
  input  logic [DATA_W-1:0] Imm,
  input  logic [DATA_W-1:0] DataIn,
  output logic              OutValid,
  output logic [DATA_W-1:0] DataOut,
  output logic              Z,
  output logic              N,
  output logic              C
);

  localparam int CW = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SHL   = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_PASSA = 4'd7;
  localparam logic [3:0] OP_LOADI = 4'd8;
  localparam logic [3:0] OP_LOAD  = 4'd9;
  localparam logic [3:0] OP_CMP   = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0]   rf [REG_NUM];
  logic [DATA_W-1:0]   op_a, op_b;
  logic                accept;
  logic                is_mul;

  logic [DATA_W:0]     sum_w, diff_w;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                alu_wr;
  logic                alu_upd;

  logic [DATA_W-1:0]   mul_a, mul_b;
  logic [AW-1:0]       mul_wa;
  logic [2*DATA_W-1:0] acc, acc_nxt, mul_addend;
  logic [CW-1:0]       cnt;
  logic                mul_last;

  logic [DATA_W-1:0]   data_out;
  logic                z_q, n_q, c_q, out_valid;

  assign op_a   = rf[RAA];
  assign op_b   = rf[RBA];
  assign is_mul = (Op == OP_MUL);

  // Ready is forced high during reset so the source sees a clean handshake
  // the moment reset releases; accepts are still blocked while Reset is high.
  assign InReady = Reset || (state == S_IDLE);
  assign accept  = InValid && !Reset && (state == S_IDLE);

  assign sum_w  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_w = {1'b0, op_a} - {1'b0, op_b};

  // One shift-add step: add the multiplicand shifted by cnt if multiplier bit cnt is set
  assign mul_addend = mul_b[cnt] ? ({{DATA_W{1'b0}}, mul_a} << cnt) : '0;
  assign acc_nxt    = acc + mul_addend;
  assign mul_last   = (state == S_MUL) && (cnt == CW'(DATA_W - 1));

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && is_mul) state_nxt = S_MUL;
      S_MUL:  if (mul_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle ALU: result, carry, and whether it writes the RF / updates outputs
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_wr  = 1'b0;
    alu_upd = 1'b0;
    case (Op)
      OP_ADD: begin
        alu_res = sum_w[DATA_W-1:0];
        alu_c   = sum_w[DATA_W];
        alu_wr  = 1'b1;
        alu_upd = 1'b1;
      end
      OP_SUB: begin
        alu_res = diff_w[DATA_W-1:0];
        alu_c   = diff_w[DATA_W];
        alu_wr  = 1'b1;
        alu_upd = 1'b1;
      end
      OP_AND: begin
        alu_res = op_a & op_b;
        alu_wr  = 1'b1;
        alu_upd = 1'b1;
      end
      OP_OR: begin
        alu_res = op_a | op_b;
        alu_wr  = 1'b1;
        alu_upd = 1'b1;
      end
      OP_XOR: begin
        alu_res = op_a ^ op_b;
        alu_wr  = 1'b1;
        alu_upd = 1'b1;
      end
      OP_SHL: begin
        alu_res = {op_a[DATA_W-2:0], 1'b0};
        alu_c   = op_a[DATA_W-1];
        alu_wr  = 1'b1;
        alu_upd = 1'b1;
      end
      OP_SHR: begin
        alu_res = {1'b0, op_a[DATA_W-1:1]};
        alu_c   = op_a[0];
        alu_wr  = 1'b1;
        alu_upd = 1'b1;
      end
      OP_PASSA: begin
        alu_res = op_a;
        alu_wr  = 1'b1;
        alu_upd = 1'b1;
      end
      OP_LOADI: begin
        alu_res = Imm;
        alu_wr  = 1'b1;
        alu_upd = 1'b1;
      end
      OP_LOAD: begin
        alu_res = DataIn;
        alu_wr  = 1'b1;
        alu_upd = 1'b1;
      end
      OP_CMP: begin
        alu_res = diff_w[DATA_W-1:0];
        alu_c   = diff_w[DATA_W];
        alu_upd = 1'b1;
      end
      default: begin
        alu_res = '0;
      end
    endcase
  end

  // Datapath: register file, multiplier registers, result and flags
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < REG_NUM; i++) rf[i] <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_wa    <= '0;
      acc       <= '0;
      cnt       <= '0;
      data_out  <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      c_q       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !is_mul) begin
        if (alu_wr) rf[WA] <= alu_res;
        if (alu_upd) begin
          data_out <= alu_res;
          z_q      <= (alu_res == '0);
          n_q      <= alu_res[DATA_W-1];
          c_q      <= alu_c;
        end
        out_valid <= 1'b1;
      end
      if (accept && is_mul) begin
        mul_a  <= op_a;
        mul_b  <= op_b;
        mul_wa <= WA;
        acc    <= '0;
        cnt    <= '0;
      end
      if (state == S_MUL) begin
        acc <= acc_nxt;
        cnt <= cnt + CW'(1);
        if (mul_last) begin
          rf[mul_wa] <= acc_nxt[DATA_W-1:0];
          data_out   <= acc_nxt[DATA_W-1:0];
          z_q        <= (acc_nxt[DATA_W-1:0] == '0);
          n_q        <= acc_nxt[DATA_W-1];
          c_q        <= (acc_nxt[2*DATA_W-1:DATA_W] != '0);
          out_valid  <= 1'b1;
        end
      end
    end
  end

  assign DataOut  = data_out;
  assign Z        = z_q;
  assign N        = n_q;
  assign C        = c_q;
  assign OutValid = out_valid;

endmodule

// File: tb/tb_calc_core.sv
// Scoreboard bench for calc_core: expected results are queued when each
// instruction is driven and compared when OutValid strobes.
module tb_calc_core;

  localparam int DW = 10;
  localparam int RN = 4;
  localparam int AW = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          z;
    logic          n;
    logic          c;
  } exp_t;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          InValid;
  logic          InReady;
  logic [3:0]    Op;
  logic [AW-1:0] WA, RAA, RBA;
  logic [DW-1:0] Imm, DataIn;
  logic          OutValid;
  logic [DW-1:0] DataOut;
  logic          Z, N, C;

  calc_core #(.DATA_W(DW), .REG_NUM(RN)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Op(Op), .WA(WA), .RAA(RAA), .RBA(RBA), .Imm(Imm), .DataIn(DataIn),
    .OutValid(OutValid), .DataOut(DataOut), .Z(Z), .N(N), .C(C)
  );

  always #5 Clock = ~Clock;

  int   n_cmp = 0;
  int   n_err = 0;
  int   ov_cnt = 0;
  exp_t sb[$];

  logic [DW-1:0] m_rf [RN];
  exp_t          m_out;

  // Count a comparison and report any mismatch
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of one instruction
  function automatic void model(input logic [3:0] op, input logic [DW-1:0] a, b, imm, din,
                                output logic [DW-1:0] res, output logic cf,
                                output bit wr, output bit upd);
    logic [DW:0]     s;
    logic [2*DW-1:0] p;
    res = '0; cf = 1'b0; wr = 1'b1; upd = 1'b1;
    case (op)
      4'd0:  begin s = {1'b0, a} + {1'b0, b}; res = s[DW-1:0]; cf = s[DW]; end
      4'd1:  begin res = a - b; cf = (a < b); end
      4'd2:  res = a & b;
      4'd3:  res = a | b;
      4'd4:  res = a ^ b;
      4'd5:  begin res = a << 1; cf = a[DW-1]; end
      4'd6:  begin res = a >> 1; cf = a[0]; end
      4'd7:  res = a;
      4'd8:  res = imm;
      4'd9:  res = din;
      4'd10: begin res = a - b; cf = (a < b); wr = 0; end
      4'd11: begin p = a * b; res = p[DW-1:0]; cf = (p[2*DW-1:DW] != '0); end
      default: begin wr = 0; upd = 0; end
    endcase
  endfunction

  // Drive one instruction, queue its expected output, wait for acceptance
  task automatic issue(input logic [3:0] op, input int wa, input int raa, input int rba,
                       input logic [DW-1:0] imm, input logic [DW-1:0] din, input bit want_out);
    logic [DW-1:0] res;
    logic          cf;
    bit            wr, upd;
    int            k;
    model(op, m_rf[raa], m_rf[rba], imm, din, res, cf, wr, upd);
    Op = op; WA = AW'(wa); RAA = AW'(raa); RBA = AW'(rba); Imm = imm; DataIn = din;
    InValid = 1'b1;
    k = 0;
    while (!InReady && k < 100) begin
      @(posedge Clock); #1;
      k++;
    end
    if (k >= 100) chk("accept_timeout", 0, 1);
    @(posedge Clock); #1;
    InValid = 1'b0;
    if (wr) m_rf[wa] = res;
    if (upd) m_out = '{d: res, z: (res == '0), n: res[DW-1], c: cf};
    if (want_out) sb.push_back(m_out);
  endtask

  task automatic model_reset();
    for (int i = 0; i < RN; i++) m_rf[i] = '0;
    m_out = '0;
  endtask

  // Scoreboard: compare every OutValid strobe against the queue
  always @(negedge Clock) begin
    exp_t e;
    if (Reset) begin
      chk("ov_in_reset", OutValid, 0);
      chk("ready_in_reset", InReady, 1);
    end else if (OutValid) begin
      ov_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_outvalid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("dataout", DataOut, e.d);
        chk("flag_z", Z, e.z);
        chk("flag_n", N, e.n);
        chk("flag_c", C, e.c);
      end
    end
  end

  initial begin
    int lo, ov0, k;
    Reset = 1'b1; InValid = 1'b0; Op = '0; WA = '0; RAA = '0; RBA = '0;
    Imm = '0; DataIn = '0;
    model_reset();
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    chk("rst_ready", InReady, 1);
    chk("rst_ov", OutValid, 0);
    chk("rst_dout", DataOut, 0);
    chk("rst_zncf", {Z, N, C}, 3'b000);

    // Read-back after reset
    issue(4'd8, 1, 0, 0, 10'h000, 0, 1);
    issue(4'd7, 2, 1, 0, 0, 0, 1);

    // Back-to-back with carry-out, one strobe per cycle
    repeat (2) @(posedge Clock); #1;
    ov0 = ov_cnt;
    issue(4'd8, 1, 0, 0, 10'h3FF, 0, 1);
    chk("b2b_ov0", OutValid, 1);
    issue(4'd8, 2, 0, 0, 10'h001, 0, 1);
    chk("b2b_ov1", OutValid, 1);
    issue(4'd0, 3, 1, 2, 0, 0, 1);
    chk("b2b_ov2", OutValid, 1);
    @(posedge Clock); #1;
    chk("b2b_ov_idle", OutValid, 0);
    chk("b2b_count", ov_cnt - ov0, 3);

    // CMP R2,R1 and R3 unchanged
    issue(4'd10, 3, 2, 1, 0, 0, 1);
    issue(4'd7, 0, 3, 0, 0, 0, 1);

    // Shift boundaries
    issue(4'd8, 1, 0, 0, 10'h200, 0, 1);
    issue(4'd5, 0, 1, 0, 0, 0, 1);
    issue(4'd8, 1, 0, 0, 10'h001, 0, 1);
    issue(4'd6, 0, 1, 0, 0, 0, 1);

    // LOAD and NOP
    issue(4'd9, 0, 0, 0, 0, 10'h2A5, 1);
    issue(4'd13, 2, 0, 0, 0, 0, 1);

    // MUL 25x40 with ignored InValid pulses during the busy window
    issue(4'd8, 1, 0, 0, 10'd25, 0, 1);
    issue(4'd8, 2, 0, 0, 10'd40, 0, 1);
    issue(4'd11, 3, 1, 2, 0, 0, 1);
    lo = 0;
    while (!InReady && lo < 40) begin
      InValid = lo[0]; Op = 4'd8; WA = 2'd0; Imm = 10'h155;
      @(posedge Clock); #1;
      lo++;
    end
    InValid = 1'b0;
    chk("mul_busy_cycles", lo, DW);
    chk("mul_done_ov", OutValid, 1);
    issue(4'd7, 0, 0, 0, 0, 0, 1);
    issue(4'd7, 0, 3, 0, 0, 0, 1);

    // MUL 40x40 overflows
    issue(4'd11, 3, 2, 2, 0, 0, 1);
    issue(4'd7, 0, 3, 0, 0, 0, 1);

    // Reset on the 5th MUL cycle aborts the multiply
    issue(4'd11, 3, 2, 1, 0, 0, 0);
    repeat (4) @(posedge Clock);
    #1 Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    model_reset();
    chk("abort_ready", InReady, 1);
    chk("abort_ov", OutValid, 0);
    repeat (12) @(posedge Clock); #1;
    for (int r = 0; r < RN; r++) issue(4'd7, r, r, 0, 0, 0, 1);

    // Reset coincident with an accept edge drops the instruction
    repeat (2) @(posedge Clock); #1;
    Reset = 1'b1; InValid = 1'b1; Op = 4'd8; WA = 2'd1; Imm = 10'h2AA;
    @(posedge Clock); #1;
    Reset = 1'b0; InValid = 1'b0;
    model_reset();
    issue(4'd7, 0, 1, 0, 0, 0, 1);

    // Random mix including dependent ops and multiplies
    for (int i = 0; i < 60; i++)
      issue(4'($urandom_range(0, 15)), $urandom_range(0, RN - 1), $urandom_range(0, RN - 1),
            $urandom_range(0, RN - 1), DW'($urandom), DW'($urandom), 1);

    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(posedge Clock); #1;
      k++;
    end
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/calc_core.md
# calc_core

Parametrised, handshaked successor to the team's register-file-plus-ALU datapath. It holds a REG_NUM × DATA_W register file and executes one instruction per accepted request. Instructions include the single-cycle ALU/load operations and a multi-cycle shift-add multiply. It produces a registered result, Z/N/C flags and a one-cycle result strobe, and sits between the control sequencer (instruction source) and the output/bus logic.

## Interface
- DATA_W, 10, datapath and register width (≥2)
- REG_NUM, 4, number of registers (power of two, ≥2); AW = $clog2(REG_NUM)
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  reset is synchronous and active-high
- InValid  in  1  instruction present
- InReady  out  1  core can accept; instruction accepted on edge where InValid && InReady
- Op  in  4  opcode (see Operation)
- WA  in  AW  destination register
- RAA  in  AW  source A register
- RBA  in  AW  source B register
- Imm  in  DATA_W  immediate for LOADI
- DataIn  in  DATA_W  external operand for LOAD
- OutValid  out  1  one-cycle strobe: DataOut/flags updated by the instruction just completed
- DataOut  out  DATA_W  registered result
- Z, N, C  out  1 each  registered flags

## Operation
- Opcodes:
  - 0 ADD A+B
  - 1 SUB A−B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SHL A<<1
  - 6 SHR A>>1 (logical)
  - 7 PASSA
  - 8 LOADI (Imm)
  - 9 LOAD (DataIn)
  - 10 CMP (A−B, no RF write)
  - 11 MUL (A×B, low DATA_W bits)
  - 12–15 NOP
- Operands A = R[RAA], B = R[RBA]: read combinationally from the RF state at the accept edge. Imm and DataIn are sampled at the accept edge.
- All arithmetic is unsigned, modulo 2^DATA_W.
- Flag rules:
  - Z = (result == 0); N = result[DATA_W-1].
  - C = carry-out for ADD; borrow (A < B) for SUB/CMP; shifted-out bit for SHL/SHR; for MUL, C = 1 iff product bits [2·DATA_W-1:DATA_W] ≠ 0; C = 0 for AND/OR/XOR/PASSA/LOADI/LOAD.
- Effects by opcode:
  - Every opcode 0–11 updates DataOut and Z/N/C.
  - Opcodes 0–9 and 11 write the result to R[WA]; CMP writes nothing.
  - NOP: no RF write; DataOut and flags hold; OutValid still pulses.
- State machine:
  - IDLE: InReady = 1. Accepting a non-MUL op completes it at the same edge; state stays IDLE. Accepting MUL latches A, B, WA, clears the product accumulator, sets cnt = 0 and goes to MUL.
  - MUL: InReady = 0. Each cycle does one shift-add step on the multiplier bit cnt, then cnt++. The edge that performs step DATA_W-1 writes R[WA], DataOut and flags, and returns to IDLE.
- InValid asserted while InReady = 0 is ignored; nothing is queued. The source must hold the instruction until accepted.
- Reset clears all registers, DataOut, Z, N, C, OutValid, cnt and the accumulator, and forces IDLE. InReady = 1 in the cycle after Reset deasserts, and also while Reset is asserted. InValid is ignored during Reset.

## Timing
- Non-MUL accepted at edge e:
  - R[WA], DataOut and flags are valid from edge e; OutValid = 1 for the cycle following e.
  - Throughput is one instruction per cycle.
  - A dependent instruction accepted at e+1 sees the new R[WA] (no forwarding hazard).
- MUL accepted at edge e:
  - InReady = 0 for the DATA_W cycles after e.
  - Result, flags and OutValid appear after edge e+DATA_W; InReady = 1 again in that same cycle. Latency is DATA_W cycles.
- WA == RAA or WA == RBA: operands are the pre-write values. MUL uses its latched operands, so it is unaffected by its own write.
- OutValid is a pulse with no backpressure; the consumer must capture it in that cycle.
- Reset asserted mid-MUL: the multiply is aborted, with no RF write and no OutValid.
- Reset coincident with an accept edge: reset wins and the instruction is dropped.

## Test plan
- Reset, then read-back:
  - LOADI R1 ← 0; PASSA R1 -> DataOut = 0, Z = 1, N = 0, C = 0.
  - OutValid = 0 throughout reset.
- LOADI R1 ← 0x3FF; LOADI R2 ← 1; ADD R3 ← R1+R2 back-to-back -> R3 = 0, Z = 1, C = 1; one OutValid per instruction on consecutive cycles.
- CMP R2,R1 (1 vs 0x3FF) -> C = 1, N = 0, DataOut = 0x002; R3 unchanged.
- SHL R1 with R1 = 0x200 -> result 0, C = 1, Z = 1; SHR of 0x001 -> 0, C = 1.
- MUL 25×40 (DATA_W = 10) -> InReady = 0 for exactly 10 cycles; InValid pulses during that window are ignored; result 1000 = 0x3E8, C = 0. Then MUL 40×40 -> 0x240, C = 1.
- Reset asserted on the 5th MUL cycle -> no write to WA, no OutValid, InReady = 1 next cycle, all registers 0.
